// File: rtl/gascon_pkg.sv
// Shared definitions for the Gascon core arbiter slice.
//   arb_state_t   : arbiter FSM states
//   GASCON_CWIDTH : default state width of the shared Gascon_Core_Round
//   KS_PORT       : requester id of the key schedule
//   DP_PORT       : requester id of the mix/absorb datapath
//   pickOwner     : round-robin pick among the two request lines
package gascon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } arb_state_t;

    localparam int unsigned GASCON_CWIDTH = 128;

    localparam logic KS_PORT = 1'b0;
    localparam logic DP_PORT = 1'b1;

    // A lone requester always wins; on contention the port that was not served last wins.
    function automatic logic pickOwner(input logic [1:0] req, input logic lastOwner);
        logic winner;
        winner = ~lastOwner;
        if (req == 2'b01) begin
            winner = KS_PORT;
        end else if (req == 2'b10) begin
            winner = DP_PORT;
        end
        return winner;
    endfunction

endpackage

// File: rtl/gascon_core_arbiter_if.sv
// Requester-side bus of the Gascon core arbiter.
//   req0/cin0 : key schedule request and state (held until rsp_valid0)
//   req1/cin1 : datapath request and state (held until rsp_valid1)
//   gnt0/gnt1 : ownership of the shared core
//   rsp_valid0/rsp_valid1 : one-cycle result pulse per requester
//   rsp_c/rsp_err         : shared result and watchdog-abort flag
// Modports: master = requester side, slave = arbiter side.
interface gascon_core_arbiter_if
    import gascon_pkg::*;
#(
    parameter int unsigned CWIDTH = GASCON_CWIDTH
);

    logic              req0;
    logic [CWIDTH-1:0] cin0;
    logic              req1;
    logic [CWIDTH-1:0] cin1;
    logic              gnt0;
    logic              gnt1;
    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [CWIDTH-1:0] rsp_c;
    logic              rsp_err;

    modport master (
        output req0, cin0, req1, cin1,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_c, rsp_err
    );

    modport slave (
        input  req0, cin0, req1, cin1,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_c, rsp_err
    );

endinterface

// File: rtl/gascon_core_arbiter.sv
// Shares one Gascon_Core_Round between the key schedule (port 0) and the
// mix/absorb datapath (port 1). Round-robin arbitration with the grant locked
// from LOAD through RESP; the core is loaded (core_reset), run (core_en), and
// its result returned to the owner with a one-cycle pulse. A watchdog aborts a
// run whose core_done never arrives and reports it through rsp_err.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : requester bus (req/cin in, gnt/rsp_valid/rsp_c/rsp_err out)
//   busy        : arbiter not idle
//   core_c      : state driven into the core (granted cin, 0 when idle)
//   core_reset  : core load pulse, also high during reset
//   core_en     : core enable, high only while running
//   core_cout   : core result
//   core_done   : core result valid
module gascon_core_arbiter
    import gascon_pkg::*;
#(
    parameter int unsigned CWIDTH  = GASCON_CWIDTH,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    gascon_core_arbiter_if.slave  bus,
    output logic                  busy,
    output logic [CWIDTH-1:0]     core_c,
    output logic                  core_reset,
    output logic                  core_en,
    input  logic [CWIDTH-1:0]     core_cout,
    input  logic                  core_done
);

    localparam int unsigned WdWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);

    arb_state_t        state;
    logic              owner;
    logic              lastOwner;
    logic [WdWidth-1:0] watchdog;
    logic [1:0]        gnt;
    logic [1:0]        rspValid;
    logic [CWIDTH-1:0] rspC;
    logic              rspErr;
    logic              busyQ;
    logic              coreEnQ;

    logic [1:0]        reqs;
    logic              winner;

    assign reqs   = {bus.req1, bus.req0};
    assign winner = pickOwner(reqs, lastOwner);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= KS_PORT;
            lastOwner <= DP_PORT;  // port 0 wins the first contention
            watchdog  <= '0;
            gnt       <= '0;
            rspValid  <= '0;
            rspC      <= '0;
            rspErr    <= 1'b0;
            busyQ     <= 1'b0;
            coreEnQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|reqs) begin
                        owner <= winner;
                        gnt   <= winner ? 2'b10 : 2'b01;
                        busyQ <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    watchdog <= '0;
                    coreEnQ  <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (core_done) begin
                        rspC     <= core_cout;
                        rspErr   <= 1'b0;
                        coreEnQ  <= 1'b0;
                        rspValid <= owner ? 2'b10 : 2'b01;
                        state    <= RESP;
                    end else if (watchdog == WdLast) begin
                        rspC     <= '0;
                        rspErr   <= 1'b1;
                        coreEnQ  <= 1'b0;
                        rspValid <= owner ? 2'b10 : 2'b01;
                        state    <= RESP;
                    end else begin
                        watchdog <= watchdog + WdWidth'(1);
                    end
                end
                RESP: begin
                    rspValid  <= '0;
                    gnt       <= '0;
                    busyQ     <= 1'b0;
                    lastOwner <= owner;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_c = '0;
        if (state != IDLE) begin
            core_c = owner ? bus.cin1 : bus.cin0;
        end
    end

    assign core_reset     = reset | (state == LOAD);
    assign core_en        = coreEnQ;
    assign busy           = busyQ;

    assign bus.gnt0       = gnt[0];
    assign bus.gnt1       = gnt[1];
    assign bus.rsp_valid0 = rspValid[0];
    assign bus.rsp_valid1 = rspValid[1];
    assign bus.rsp_c      = rspC;
    assign bus.rsp_err    = rspErr;

endmodule
